// File: rtl/seq_borrow_subtractor_pkg.sv
// Shared types and constants for the digit-serial borrow subtractor.
package seq_borrow_subtractor_pkg;

   // Bits handled per RUN cycle; matches the 4-bit look-ahead slice.
   localparam int DIGIT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Digits per operation for a given operand width (width is a multiple of DIGIT_W).
   function automatic int ndig_of(input int width);
      return width / DIGIT_W;
   endfunction

   // Digit counter width; a single-digit datapath still needs a 1-bit counter.
   function automatic int cnt_w_of(input int ndig);
      return (ndig > 1) ? $clog2(ndig) : 1;
   endfunction

endpackage

// File: rtl/seq_borrow_subtractor_slice.sv
// 4-bit borrow-look-ahead subtractor slice: diff = a - b - bin, built as
// a + ~b with carry-in ~bin, so the borrow-out is the inverted carry-out.
module borrow_look_ahead_subtractor_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       bin,
   output logic [3:0] diff,
   output logic       bout
);

   logic [3:0] nb;
   logic [3:0] p;
   logic [3:0] g;
   logic [4:0] c;

   assign nb = ~b;
   assign p  = a ^ nb;
   assign g  = a & nb;

   // Flat look-ahead carries: every carry depends only on p, g and c[0].
   assign c[0] = ~bin;
   assign c[1] = g[0] | (p[0] & c[0]);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & c[0]);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c[0]);

   assign diff = p ^ c[3:0];
   assign bout = ~c[4];

endmodule

// File: rtl/seq_borrow_subtractor.sv
// Digit-serial WIDTH-bit subtractor: diff = a - b - bin, one 4-bit digit per
// cycle, LSD first, with valid/ready handshakes on input and output.
module seq_borrow_subtractor
   import seq_borrow_subtractor_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             zero
);

   localparam int               NDIG  = ndig_of(WIDTH);
   localparam int               CNT_W = cnt_w_of(NDIG);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(NDIG - 1);

   state_t             state;
   state_t             state_next;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   diff_q;
   logic [WIDTH-1:0]   diff_merged;
   logic [CNT_W-1:0]   cnt;
   logic               borrow;
   logic               bout_q;
   logic               ovf_q;
   logic               zero_q;
   logic [DIGIT_W-1:0] a_dig;
   logic [DIGIT_W-1:0] b_dig;
   logic [DIGIT_W-1:0] s_diff;
   logic               s_bout;
   logic               accept;
   logic               last_dig;

   assign accept   = (state == IDLE) && in_valid;
   assign last_dig = (state == RUN) && (cnt == LAST);

   // One shared slice, time-multiplexed across the digits by cnt.
   borrow_look_ahead_subtractor_4bit u_slice (
      .a    (a_dig),
      .b    (b_dig),
      .bin  (borrow),
      .diff (s_diff),
      .bout (s_bout)
   );

   // Select the current digit and merge the slice result into the partial diff.
   always_comb begin
      a_dig       = a_q[int'(cnt)*DIGIT_W +: DIGIT_W];
      b_dig       = b_q[int'(cnt)*DIGIT_W +: DIGIT_W];
      diff_merged = diff_q;
      diff_merged[int'(cnt)*DIGIT_W +: DIGIT_W] = s_diff;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state and handshake outputs; result is offered only in DONE.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_next = RUN;
         end
         RUN: begin
            if (last_dig) state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Operand capture, digit iteration and result/flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: operand and result registers are reset too; they are plain flops, not a RAM.
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         diff_q <= '0;
         cnt    <= '0;
         borrow <= 1'b0;
         bout_q <= 1'b0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else if (accept) begin
         a_q    <= a;
         b_q    <= b;
         borrow <= bin;
         cnt    <= '0;
         diff_q <= '0;
      end else if (state == RUN) begin
         diff_q <= diff_merged;
         borrow <= s_bout;
         cnt    <= last_dig ? '0 : cnt + 1'b1;
         // Flags are taken from the completed diff on the final digit.
         if (last_dig) begin
            bout_q <= s_bout;
            ovf_q  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_merged[WIDTH-1] != a_q[WIDTH-1]);
            zero_q <= (diff_merged == '0);
         end
      end
   end

   assign diff = diff_q;
   assign bout = bout_q;
   assign ovf  = ovf_q;
   assign zero = zero_q;

endmodule

// File: tb/tb_seq_borrow_subtractor.sv
// Scoreboard bench for seq_borrow_subtractor at WIDTH=16 and WIDTH=4.
module tb_seq_borrow_subtractor;

   typedef struct packed {
      logic [15:0] diff;
      logic        bout;
      logic        ovf;
      logic        zero;
   } exp_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;

   logic        in_valid16 = 1'b0, bin16 = 1'b0, out_ready16 = 1'b1;
   logic [15:0] a16 = '0, b16 = '0;
   logic        in_ready16, out_valid16, bout16, ovf16, zero16;
   logic [15:0] diff16;

   logic        in_valid4 = 1'b0, bin4 = 1'b0, out_ready4 = 1'b1;
   logic [3:0]  a4 = '0, b4 = '0;
   logic        in_ready4, out_valid4, bout4, ovf4, zero4;
   logic [3:0]  diff4;

   int   total = 0;
   int   bad   = 0;
   exp_t q16[$];
   exp_t q4[$];
   exp_t m16, m4;

   always #5 clk = ~clk;

   seq_borrow_subtractor #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
      .a(a16), .b(b16), .bin(bin16), .out_valid(out_valid16), .out_ready(out_ready16),
      .diff(diff16), .bout(bout16), .ovf(ovf16), .zero(zero16)
   );

   seq_borrow_subtractor #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
      .a(a4), .b(b4), .bin(bin4), .out_valid(out_valid4), .out_ready(out_ready4),
      .diff(diff4), .bout(bout4), .ovf(ovf4), .zero(zero4)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [15:0] d, input logic bo, input logic ov, input logic z);
      exp_t e;
      e.diff = d;
      e.bout = bo;
      e.ovf  = ov;
      e.zero = z;
      return e;
   endfunction

   // Reference: {bout, diff} = a - b - bin at width w.
   function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b, input logic bin);
      exp_t        e;
      int          d;
      int          mask;
      int unsigned ai;
      int unsigned bi;
      ai     = 32'(a);
      bi     = 32'(b);
      mask   = (1 << w) - 1;
      d      = int'(ai) - int'(bi) - int'({31'b0, bin});
      e.diff = 16'(d & mask);
      e.bout = (ai < bi + 32'(bin));
      e.ovf  = (a[w-1] != b[w-1]) && (e.diff[w-1] != a[w-1]);
      e.zero = (e.diff == 16'h0);
      return e;
   endfunction

   task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic bin,
                          input exp_t e, input bit push);
      bit ok;
      ok = 1'b0;
      @(negedge clk);
      a16 = a; b16 = b; bin16 = bin; in_valid16 = 1'b1;
      for (int i = 0; i < 100 && !ok; i++) begin
         if (in_ready16) begin
            if (push) q16.push_back(e);
            ok = 1'b1;
         end
         @(negedge clk);
      end
      in_valid16 = 1'b0;
      check("accept16", 32'(ok), 32'd1);
   endtask

   task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic bin, input exp_t e);
      bit ok;
      ok = 1'b0;
      @(negedge clk);
      a4 = a; b4 = b; bin4 = bin; in_valid4 = 1'b1;
      for (int i = 0; i < 100 && !ok; i++) begin
         if (in_ready4) begin
            q4.push_back(e);
            ok = 1'b1;
         end
         @(negedge clk);
      end
      in_valid4 = 1'b0;
      check("accept4", 32'(ok), 32'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && (q16.size() != 0 || q4.size() != 0); i++) @(negedge clk);
      check("drain16", 32'(q16.size()), 32'd0);
      check("drain4", 32'(q4.size()), 32'd0);
   endtask

   // Monitors: pop and compare on every output handshake.
   always begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid16 && out_ready16) begin
         if (q16.size() == 0) begin
            check("spurious_out16", 32'(out_valid16), 32'd0);
         end else begin
            m16 = q16.pop_front();
            check("diff16", 32'(diff16), 32'(m16.diff));
            check("bout16", 32'(bout16), 32'(m16.bout));
            check("ovf16",  32'(ovf16),  32'(m16.ovf));
            check("zero16", 32'(zero16), 32'(m16.zero));
         end
      end
   end

   always begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid4 && out_ready4) begin
         if (q4.size() == 0) begin
            check("spurious_out4", 32'(out_valid4), 32'd0);
         end else begin
            m4 = q4.pop_front();
            check("diff4", 32'(diff4), 32'(m4.diff));
            check("bout4", 32'(bout4), 32'(m4.bout));
            check("ovf4",  32'(ovf4),  32'(m4.ovf));
            check("zero4", 32'(zero4), 32'(m4.zero));
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      bit seen;
      logic [15:0] ra, rb;
      logic        rbin;

      // Reset state.
      #1 rst_n = 1'b0;
      #2;
      check("rst_out_valid", 32'(out_valid16), 32'd0);
      check("rst_diff", 32'(diff16), 32'd0);
      check("rst_flags", 32'({bout16, ovf16, zero16}), 32'd0);
      check("rst_in_ready", 32'(in_ready16), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Latency and first result.
      issue16(16'h1234, 16'h0235, 1'b0, mk(16'h0FFF, 1'b0, 1'b0, 1'b0), 1'b1);
      lat = 1;
      while (!out_valid16 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      check("latency16", 32'(lat), 32'd5);
      drain();

      // Directed 16-bit vectors.
      issue16(16'h0000, 16'h0001, 1'b0, mk(16'hFFFF, 1'b1, 1'b0, 1'b0), 1'b1);
      issue16(16'h8000, 16'h0001, 1'b0, mk(16'h7FFF, 1'b0, 1'b1, 1'b0), 1'b1);
      issue16(16'h0010, 16'h000F, 1'b1, mk(16'h0000, 1'b0, 1'b0, 1'b1), 1'b1);
      issue16(16'h5555, 16'h5555, 1'b0, mk(16'h0000, 1'b0, 1'b0, 1'b1), 1'b1);
      issue16(16'h7FFF, 16'hFFFF, 1'b0, mk(16'h8000, 1'b1, 1'b1, 1'b0), 1'b1);
      drain();

      // Busy input: a request during RUN must be ignored.
      issue16(16'h8000, 16'h0001, 1'b0, mk(16'h7FFF, 1'b0, 1'b1, 1'b0), 1'b1);
      a16 = 16'hFFFF; b16 = 16'h0000; bin16 = 1'b0; in_valid16 = 1'b1;
      #1 check("busy_in_ready", 32'(in_ready16), 32'd0);
      @(negedge clk);
      in_valid16 = 1'b0;
      drain();

      // Backpressure: result must hold while out_ready is low.
      out_ready16 = 1'b0;
      issue16(16'h1234, 16'h0235, 1'b0, mk(16'h0FFF, 1'b0, 1'b0, 1'b0), 1'b1);
      for (int i = 0; i < 50 && !out_valid16; i++) @(negedge clk);
      check("bp_valid", 32'(out_valid16), 32'd1);
      repeat (5) begin
         @(negedge clk);
         #1;
         check("bp_hold_valid", 32'(out_valid16), 32'd1);
         check("bp_hold_diff", 32'(diff16), 32'h0FFF);
         check("bp_hold_flags", 32'({bout16, ovf16, zero16}), 32'd0);
         check("bp_in_ready", 32'(in_ready16), 32'd0);
      end
      @(negedge clk);
      out_ready16 = 1'b1;
      #1 check("hs_in_ready", 32'(in_ready16), 32'd0);
      @(negedge clk);
      #1 check("idle_in_ready", 32'(in_ready16), 32'd1);
      check("idle_out_valid", 32'(out_valid16), 32'd0);
      drain();

      // Reset during RUN digit 2: abandoned, no result.
      issue16(16'h0000, 16'h0001, 1'b0, mk(16'hFFFF, 1'b1, 1'b0, 1'b0), 1'b0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("abort_out_valid", 32'(out_valid16), 32'd0);
      check("abort_diff", 32'(diff16), 32'd0);
      check("abort_flags", 32'({bout16, ovf16, zero16}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("abort_in_ready", 32'(in_ready16), 32'd1);
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         seen |= out_valid16;
      end
      check("abort_no_result", 32'(seen), 32'd0);

      // Directed 4-bit vectors, single RUN cycle.
      issue4(4'h3, 4'h5, 1'b0, mk(16'h000E, 1'b1, 1'b0, 1'b0));
      lat = 1;
      while (!out_valid4 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      check("latency4", 32'(lat), 32'd2);
      issue4(4'h8, 4'h1, 1'b0, mk(16'h0007, 1'b0, 1'b1, 1'b0));
      issue4(4'h7, 4'h6, 1'b1, mk(16'h0000, 1'b0, 1'b0, 1'b1));
      issue4(4'h0, 4'hF, 1'b1, mk(16'h0000, 1'b1, 1'b0, 1'b1));
      drain();

      // Random regression on both widths in parallel.
      fork
         begin
            for (int i = 0; i < 3000; i++) begin
               ra   = 16'($urandom);
               rb   = 16'($urandom);
               rbin = 1'($urandom);
               issue16(ra, rb, rbin, model(16, ra, rb, rbin), 1'b1);
            end
         end
         begin
            logic [3:0] xa, xb;
            logic       xbin;
            for (int j = 0; j < 3000; j++) begin
               xa   = 4'($urandom);
               xb   = 4'($urandom);
               xbin = 1'($urandom);
               issue4(xa, xb, xbin, model(4, {12'h0, xa}, {12'h0, xb}, xbin));
            end
         end
      join
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
